rca_multiword_adder: RTL and testbench

Sequential wide-operand adder that adds two N*WORDS-bit operands one N-bit slice per cycle through a single combinational ripple-carry adder. The inter-slice carry is registered. It sits directly around the rca stage: it feeds that stage each slice plus the carry, and consumes its S/Co back into a result register. Operands arrive and results leave over valid/ready handshakes, so a narrow adder serves wide datapaths without long combinational carry chains.

---
 rtl/rca_pkg.sv | 24 ++
 rtl/full_adder.sv | 11 +
 rtl/rca.sv | 26 ++
 rtl/rca_multiword_adder.sv | 100 ++++++++++
 tb/tb_rca_multiword_adder.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/rca_pkg.sv
// Shared types and helpers for the multi-word ripple-carry adder.
package rca_pkg;

    localparam int unsigned WORDS_MAX = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/rca.sv
// N-bit combinational ripple-carry adder built from full adders.
module rca #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);
    logic [N:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < int'(N); i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co = c[N];
endmodule

// File: rtl/rca_multiword_adder.sv
// Wide adder that pushes one N-bit slice per cycle through a single rca,
// carrying between slices in a register; valid/ready on both sides.
module rca_multiword_adder
    import rca_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic               ci,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] sum,
    output logic               co
);
    localparam int unsigned W     = N * WORDS;
    localparam int unsigned IDX_W = (clog2(WORDS) > 0) ? clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    state_t           state, state_next;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [W-1:0]     a_reg, b_reg;
    logic [N-1:0]     slice_a, slice_b, slice_s;
    logic             slice_co;

    assign slice_a = a_reg[idx*N +: N];
    assign slice_b = b_reg[idx*N +: N];

    rca #(.N(N)) u_rca (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    // State register; handshake flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid && in_ready) state_next = RUN;
            RUN:     if (idx == LAST)          state_next = DONE;
            DONE:    if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture and per-slice accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            sum   <= '0;
            co    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= ci;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum[idx*N +: N] <= slice_s;
                    carry           <= slice_co;
                    if (idx == LAST) begin
                        co  <= slice_co;
                        idx <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_multiword_adder.sv
// Self-checking bench: directed table, backpressure, reset abort, WORDS=1 and random back-to-back.
module tb_rca_multiword_adder;

    localparam int unsigned N  = 4;
    localparam int unsigned WD = 4;
    localparam int unsigned W  = N * WD;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, ci, co;
    logic [W-1:0] a, b, sum;

    logic         in_valid1, in_ready1, out_valid1, out_ready1, ci1, co1;
    logic [N-1:0] a1, b1, sum1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rca_multiword_adder #(.N(N), .WORDS(WD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .co(co)
    );

    rca_multiword_adder #(.N(N), .WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .ci(ci1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .co(co1)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] exp_sum;
        logic         exp_co;
    } vec_t;

    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: full-width addition, split into truncated sum and overflow.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one operand set (DUT idle, at #1 after an edge); return cycles to out_valid.
    task automatic start_and_wait(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                  input logic xc, input logic hold_valid, output int lat);
        a = xa; b = xb; ci = xc; in_valid = 1'b1;
        step();
        if (hold_valid) begin
            a = ~xa; b = ~xb; ci = ~xc;
        end else begin
            in_valid = 1'b0;
        end
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    int           lat;
    logic [W:0]   r;
    logic [W-1:0] ra, rb;
    logic         rc;
    realtime      t_acc, t_prev;
    int           waitc;

    initial begin
        vecs[0] = '{a: 16'hFFFF, b: 16'h0001, ci: 1'b0, exp_sum: 16'h0000, exp_co: 1'b1};
        vecs[1] = '{a: 16'h1234, b: 16'h4321, ci: 1'b1, exp_sum: 16'h5556, exp_co: 1'b0};
        vecs[2] = '{a: 16'h8000, b: 16'h8000, ci: 1'b0, exp_sum: 16'h0000, exp_co: 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ci = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
        #12;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_sum",       32'(sum),       32'd0);
        check("reset_co",        32'(co),        32'd0);
        rst_n = 1'b1;
        step();

        // Directed table
        for (int i = 0; i < 3; i++) begin
            start_and_wait(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(WD));
            check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].exp_sum));
            check($sformatf("vec%0d_co", i),  32'(co),  32'(vecs[i].exp_co));
            consume();
            check($sformatf("vec%0d_idle", i), 32'(in_ready), 32'd1);
        end

        // Backpressure with in_valid held high through RUN and DONE
        start_and_wait(16'hABCD, 16'h1357, 1'b1, 1'b1, lat);
        r = ref_add(16'hABCD, 16'h1357, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_sum",       32'(sum),       32'(r[W-1:0]));
            check("bp_co",        32'(co),        32'(r[W]));
            step();
        end
        in_valid = 1'b0;
        consume();
        check("bp_released_out_valid", 32'(out_valid), 32'd0);
        check("bp_released_in_ready",  32'(in_ready),  32'd1);

        // Reset mid-RUN aborts everything
        a = 16'hFFFF; b = 16'h0001; ci = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_sum",       32'(sum),       32'd0);
        check("rst_mid_co",        32'(co),        32'd0);
        check("rst_mid_in_ready",  32'(in_ready),  32'd1);
        #2;
        rst_n = 1'b1;
        step();
        start_and_wait(16'h00FF, 16'h0001, 1'b0, 1'b0, lat);
        check("post_rst_sum", 32'(sum), 32'h0100);
        check("post_rst_co",  32'(co),  32'd0);
        consume();

        // WORDS=1 instance
        a1 = 4'hF; b1 = 4'h1; ci1 = 1'b1; in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 50) begin
            step();
            lat++;
        end
        check("w1_latency", 32'(lat),  32'd1);
        check("w1_sum",     32'(sum1), 32'h1);
        check("w1_co",      32'(co1),  32'd1);
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        check("w1_idle", 32'(in_ready1), 32'd1);

        // Random back-to-back with out_ready tied high
        out_ready = 1'b1;
        t_prev = 0;
        for (int i = 0; i < 20; i++) begin
            waitc = 0;
            while (!in_ready && waitc < 50) begin
                step();
                waitc++;
            end
            if (waitc >= 50) check("rand_in_ready_timeout", 32'd1, 32'd0);
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            r = ref_add(ra, rb, rc);
            a = ra; b = rb; ci = rc; in_valid = 1'b1;
            @(posedge clk);
            t_acc = $realtime;
            #1;
            in_valid = 1'b0;
            if (i > 0) check("rand_spacing", 32'(int'((t_acc - t_prev) / 10.0)), 32'(WD + 2));
            t_prev = t_acc;
            lat = 0;
            while (!out_valid && lat < 50) begin
                step();
                lat++;
            end
            check($sformatf("rand%0d_sum", i), 32'(sum), 32'(r[W-1:0]));
            check($sformatf("rand%0d_co", i),  32'(co),  32'(r[W]));
        end
        out_ready = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
